// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter: word and RAM-state types, the
// arbiter FSM encoding, grant history and the ERROR-completion load value.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DSERVE = 2'd1,
        ISERVE = 2'd2
    } arb_state_t;

    typedef enum logic {
        DATA  = 1'b0,
        INSTR = 1'b1
    } grant_t;

    localparam word_t ERR_WORD = 32'hBAD1BAD1;
    localparam word_t CNT_MAX  = '1;

    // Saturating increment used by the performance counters.
    function automatic word_t sat_inc(input word_t v);
        return (v == CNT_MAX) ? v : v + word_t'(1);
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating access/stall counters for memory_arbiter; only instantiated when
// MEM_ARB_PERF_EN is defined.
module mem_arb_perf
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_access,
    input  logic        d_access,
    input  logic        stall,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] stallcount
);

    word_t icount_q, icount_d;
    word_t dcount_q, dcount_d;
    word_t stall_q,  stall_d;

    always_comb begin
        icount_d = icount_q;
        dcount_d = dcount_q;
        stall_d  = stall_q;
        if (i_access) icount_d = sat_inc(icount_q);
        if (d_access) dcount_d = sat_inc(dcount_q);
        if (stall)    stall_d  = sat_inc(stall_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            icount_q <= '0;
            dcount_q <= '0;
            stall_q  <= '0;
        end else begin
            icount_q <= icount_d;
            dcount_q <= dcount_d;
            stall_q  <= stall_d;
        end
    end

    assign icount     = icount_q;
    assign dcount     = dcount_q;
    assign stallcount = stall_q;

endmodule

// File: rtl/memory_arbiter.sv
// Data-first arbiter between the caches' instruction and data ports and a single
// variable-latency RAM. Optional counters: define MEM_ARB_PERF_EN.
module memory_arbiter
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic [31:0]       stallcount
`endif
);

    arb_state_t state_q,      state_d;
    grant_t     last_grant_q, last_grant_d;
    logic       mem_err_q,    mem_err_d;

    ramstate_t rs;
    logic      dreq;
    logic      complete;
    word_t     cmp_load;

    assign rs       = ramstate_t'(ramstate);
    assign dreq     = dREN | dWEN;
    assign complete = (rs == ACCESS) || (rs == ERROR);
    assign cmp_load = (rs == ERROR) ? ERR_WORD : ramload;

    // NOTE: every output and next-state value gets a default before the case so
    // no path through this block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_err_d    = mem_err_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (state_q)
            IDLE: begin
                // Instruction fetch jumps the queue only if data won last time.
                if (dreq && iREN && (last_grant_q == DATA)) state_d = ISERVE;
                else if (dreq)                              state_d = DSERVE;
                else if (iREN)                              state_d = ISERVE;
            end

            DSERVE: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (complete) begin
                        dwait        = 1'b0;
                        dload        = cmp_load;
                        last_grant_d = DATA;
                        mem_err_d    = mem_err_q | (rs == ERROR);
                        state_d      = IDLE;
                    end
                end
            end

            ISERVE: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (complete) begin
                        iwait        = 1'b0;
                        iload        = cmp_load;
                        last_grant_d = INSTR;
                        mem_err_d    = mem_err_q | (rs == ERROR);
                        state_d      = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= INSTR;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef MEM_ARB_PERF_EN
    logic i_access, d_access, stall;

    assign i_access = (state_q == ISERVE) && iREN && (rs == ACCESS);
    assign d_access = (state_q == DSERVE) && dreq && (rs == ACCESS);
    assign stall    = (state_q != IDLE) && (rs == BUSY);

    mem_arb_perf u_perf (
        .CLK        (CLK),
        .RST        (RST),
        .i_access   (i_access),
        .d_access   (d_access),
        .stall      (stall),
        .icount     (icount),
        .dcount     (dcount),
        .stallcount (stallcount)
    );
`endif

endmodule
